// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU/load result inputs, hazard query, regfile write port.
// The fwd_* forwarding signals exist only when WB_FWD_EN is defined.
interface wb_arbiter_if #(
    parameter int DATAWIDTH = 32,
    parameter int INDEX     = 5,
    parameter int DEPTH     = 4
);
    logic                     alu_valid;
    logic [INDEX-1:0]         alu_rd;
    logic [DATAWIDTH-1:0]     alu_data;
    logic                     mem_valid;
    logic                     mem_ready;
    logic [INDEX-1:0]         mem_rd;
    logic [DATAWIDTH-1:0]     mem_data;
    logic [INDEX-1:0]         ra_1;
    logic [INDEX-1:0]         ra_2;
    logic                     hz_1;
    logic                     hz_2;
    logic [$clog2(DEPTH):0]   count;
    logic                     werf;
    logic [INDEX-1:0]         wa;
    logic [DATAWIDTH-1:0]     wd;
`ifdef WB_FWD_EN
    logic                     fwd_v_1;
    logic                     fwd_v_2;
    logic [DATAWIDTH-1:0]     fwd_d_1;
    logic [DATAWIDTH-1:0]     fwd_d_2;
`endif

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, ra_1, ra_2,
`ifdef WB_FWD_EN
        output fwd_v_1, fwd_v_2, fwd_d_1, fwd_d_2,
`endif
        output mem_ready, hz_1, hz_2, count, werf, wa, wd
    );

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, ra_1, ra_2,
`ifdef WB_FWD_EN
        input  fwd_v_1, fwd_v_2, fwd_d_1, fwd_d_2,
`endif
        input  mem_ready, hz_1, hz_2, count, werf, wa, wd
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results take priority over a load FIFO with WAW kill and
// pending-write hazard reporting. Define WB_FWD_EN to add read-port forwarding outputs.
module wb_arbiter #(
    parameter int DATAWIDTH = 32,
    parameter int REGISTERS = 32,
    parameter int INDEX     = $clog2(REGISTERS),
    parameter int DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst,
    wb_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic                 live;
        logic [INDEX-1:0]     rd;
        logic [DATAWIDTH-1:0] data;
    } ent_t;

    ent_t                 fifo [DEPTH];
    logic [PW:0]          wr_ptr, rd_ptr;
    logic [PW-1:0]        wr_idx, rd_idx;
    logic                 full, empty;
    logic                 alu_win, push, pop;
    ent_t                 head;
    logic                 werf;
    logic [INDEX-1:0]     wa;
    logic [DATAWIDTH-1:0] wd;

    assign wr_idx = wr_ptr[PW-1:0];
    assign rd_idx = rd_ptr[PW-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_idx == rd_idx);
    assign head   = fifo[rd_idx];

    // rd==0 results are architecturally dead: an rd==0 ALU op never wins, an rd==0 load never enqueues
    assign alu_win = bus.alu_valid && (bus.alu_rd != '0);
    assign push    = bus.mem_valid && !full && (bus.mem_rd != '0);
    assign pop     = !alu_win && !empty;

    assign bus.mem_ready = !full;
    assign bus.count     = wr_ptr - rd_ptr;
    assign bus.werf      = werf;
    assign bus.wa        = wa;
    assign bus.wd        = wd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            werf   <= 1'b0;
            wa     <= '0;
            wd     <= '0;
            for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
        end else begin
            if (alu_win) begin
                werf <= 1'b1;
                wa   <= bus.alu_rd;
                wd   <= bus.alu_data;
            end else if (pop) begin
                werf <= head.live;
                if (head.live) begin
                    wa <= head.rd;
                    wd <= head.data;
                end
            end else begin
                werf <= 1'b0;
            end
            // Kill first; a same-cycle push below is younger and overrides its slot
            for (int i = 0; i < DEPTH; i++)
                if (alu_win && fifo[i].rd == bus.alu_rd) fifo[i].live <= 1'b0;
            if (pop) begin
                fifo[rd_idx].live <= 1'b0;
                rd_ptr            <= rd_ptr + 1'b1;
            end
            if (push) begin
                fifo[wr_idx] <= '{live: 1'b1, rd: bus.mem_rd, data: bus.mem_data};
                wr_ptr       <= wr_ptr + 1'b1;
            end
        end
    end

    // Live bits are cleared on pop, so a live slot is always an occupied slot
    logic [1:0][INDEX-1:0]     ra;
    logic [1:0]                fifo_hit, hz;
    logic [1:0][DATAWIDTH-1:0] hit_data, fwd_d;
    logic [PW-1:0]             idx;

    assign ra[0] = bus.ra_1;
    assign ra[1] = bus.ra_2;

    always_comb begin
        fifo_hit = '0;
        hit_data = '0;
        hz       = '0;
        fwd_d    = '0;
        idx      = '0;
        for (int p = 0; p < 2; p++) begin
            // Walk oldest to youngest so the last match is the youngest
            for (int k = 0; k < DEPTH; k++) begin
                idx = rd_idx + PW'(k);
                if (fifo[idx].live && fifo[idx].rd == ra[p]) begin
                    fifo_hit[p] = 1'b1;
                    hit_data[p] = fifo[idx].data;
                end
            end
            hz[p] = (ra[p] != '0) && (fifo_hit[p] || (werf && wa == ra[p]));
            if (hz[p]) fwd_d[p] = fifo_hit[p] ? hit_data[p] : wd;
        end
    end

    assign bus.hz_1 = hz[0];
    assign bus.hz_2 = hz[1];

`ifdef WB_FWD_EN
    assign bus.fwd_v_1 = hz[0];
    assign bus.fwd_v_2 = hz[1];
    assign bus.fwd_d_1 = fwd_d[0];
    assign bus.fwd_d_2 = fwd_d[1];
`else
    logic unused_fwd;
    assign unused_fwd = ^fwd_d;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, ALU priority, FIFO fill/drain, WAW kill, rd==0, hazards.
module tb_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    wb_arbiter_if #(.DATAWIDTH(32), .INDEX(5), .DEPTH(4)) bus();
    wb_arbiter #(.DATAWIDTH(32), .REGISTERS(32), .DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
    endtask

    task automatic test_reset;
        idle();
        bus.ra_1 = '0; bus.ra_2 = '0;
        #2;
        checks++; if (bus.werf !== 1'b0) begin errors++; $display("FAIL reset_werf got %0b want 0", bus.werf); end
        checks++; if (bus.wa !== 5'd0) begin errors++; $display("FAIL reset_wa got %0d want 0", bus.wa); end
        checks++; if (bus.wd !== 32'h0) begin errors++; $display("FAIL reset_wd got %h want 0", bus.wd); end
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
        checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", bus.mem_ready); end
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_alu_single;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
        tick();
        idle();
        checks++; if (bus.werf !== 1'b1) begin errors++; $display("FAIL alu_werf got %0b want 1", bus.werf); end
        checks++; if (bus.wa !== 5'd5) begin errors++; $display("FAIL alu_wa got %0d want 5", bus.wa); end
        checks++; if (bus.wd !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_wd got %h want deadbeef", bus.wd); end
        tick();
        checks++; if (bus.werf !== 1'b0) begin errors++; $display("FAIL alu_werf_after got %0b want 0", bus.werf); end
        checks++; if (bus.wa !== 5'd5) begin errors++; $display("FAIL alu_wa_hold got %0d want 5", bus.wa); end
    endtask

    task automatic test_fill_drain;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h99;
        for (int i = 1; i <= 4; i++) begin
            bus.mem_valid = 1'b1; bus.mem_rd = 5'(i); bus.mem_data = 32'h100 + i;
            tick();
        end
        checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d want 4", bus.count); end
        checks++; if (bus.mem_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %0b want 0", bus.mem_ready); end
        checks++; if (bus.wa !== 5'd9 || bus.werf !== 1'b1) begin errors++; $display("FAIL fill_alu_wa got %0d/%0b want 9/1", bus.wa, bus.werf); end
        // Offer a fifth load while full: must be refused
        bus.mem_rd = 5'd6; bus.mem_data = 32'h106;
        tick();
        checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL full_reject_count got %0d want 4", bus.count); end
        // Full + pop in the same cycle: pop happens, push still refused
        bus.alu_valid = 1'b0;
        tick();
        bus.mem_valid = 1'b0;
        checks++; if (bus.werf !== 1'b1 || bus.wa !== 5'd1 || bus.wd !== 32'h101) begin
            errors++; $display("FAIL drain_1 got %0b/%0d/%h want 1/1/101", bus.werf, bus.wa, bus.wd); end
        checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL full_pop_count got %0d want 3", bus.count); end
        for (int i = 2; i <= 4; i++) begin
            tick();
            checks++; if (bus.werf !== 1'b1 || bus.wa !== 5'(i) || bus.wd !== 32'h100 + i) begin
                errors++; $display("FAIL drain_%0d got %0b/%0d/%h want 1/%0d/%h", i, bus.werf, bus.wa, bus.wd, i, 32'h100 + i); end
        end
        tick();
        checks++; if (bus.werf !== 1'b0 || bus.count !== 3'd0) begin
            errors++; $display("FAIL drain_end got %0b/%0d want 0/0", bus.werf, bus.count); end
    endtask

    task automatic test_waw_kill;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd7; bus.mem_data = 32'h11;
        tick();
        idle();
        checks++; if (bus.werf !== 1'b0 || bus.count !== 3'd1) begin
            errors++; $display("FAIL no_fallthrough got %0b/%0d want 0/1", bus.werf, bus.count); end
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h22;
        tick();
        idle();
        checks++; if (bus.werf !== 1'b1 || bus.wa !== 5'd7 || bus.wd !== 32'h22) begin
            errors++; $display("FAIL waw_alu got %0b/%0d/%h want 1/7/22", bus.werf, bus.wa, bus.wd); end
        tick();
        checks++; if (bus.werf !== 1'b0 || bus.count !== 3'd0 || bus.wd !== 32'h22) begin
            errors++; $display("FAIL waw_killed_pop got %0b/%0d/%h want 0/0/22", bus.werf, bus.count, bus.wd); end
    endtask

    task automatic test_waw_younger;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd8; bus.mem_data = 32'hB1;
        tick();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd8; bus.alu_data = 32'hA0;
        bus.mem_data = 32'hB2;
        tick();
        idle();
        checks++; if (bus.werf !== 1'b1 || bus.wd !== 32'hA0 || bus.count !== 3'd2) begin
            errors++; $display("FAIL young_alu got %0b/%h/%0d want 1/a0/2", bus.werf, bus.wd, bus.count); end
        tick();
        checks++; if (bus.werf !== 1'b0 || bus.count !== 3'd1) begin
            errors++; $display("FAIL young_killed got %0b/%0d want 0/1", bus.werf, bus.count); end
        tick();
        checks++; if (bus.werf !== 1'b1 || bus.wa !== 5'd8 || bus.wd !== 32'hB2) begin
            errors++; $display("FAIL young_live got %0b/%0d/%h want 1/8/b2", bus.werf, bus.wa, bus.wd); end
        tick();
    endtask

    task automatic test_zero_rd;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hFFFF;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = 32'hEEEE;
        checks++; if (bus.mem_ready !== 1'b1) begin errors++; $display("FAIL zero_ready got %0b want 1", bus.mem_ready); end
        tick();
        idle();
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL zero_count got %0d want 0", bus.count); end
        checks++; if (bus.werf !== 1'b0 || bus.wa !== 5'd8 || bus.wd !== 32'hB2) begin
            errors++; $display("FAIL zero_write got %0b/%0d/%h want 0/8/b2", bus.werf, bus.wa, bus.wd); end
    endtask

    task automatic test_hazard;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd3; bus.mem_data = 32'h33;
        tick();
        idle();
        bus.ra_1 = 5'd3; bus.ra_2 = 5'd0;
        #1;
        checks++; if (bus.hz_1 !== 1'b1 || bus.hz_2 !== 1'b0) begin
            errors++; $display("FAIL hz_queued got %0b/%0b want 1/0", bus.hz_1, bus.hz_2); end
`ifdef WB_FWD_EN
        checks++; if (bus.fwd_v_1 !== 1'b1 || bus.fwd_d_1 !== 32'h33 || bus.fwd_v_2 !== 1'b0 || bus.fwd_d_2 !== 32'h0) begin
            errors++; $display("FAIL fwd_queued got %0b/%h/%0b/%h want 1/33/0/0", bus.fwd_v_1, bus.fwd_d_1, bus.fwd_v_2, bus.fwd_d_2); end
`endif
        tick();
        checks++; if (bus.werf !== 1'b1 || bus.wa !== 5'd3 || bus.hz_1 !== 1'b1) begin
            errors++; $display("FAIL hz_inflight got %0b/%0d/%0b want 1/3/1", bus.werf, bus.wa, bus.hz_1); end
`ifdef WB_FWD_EN
        checks++; if (bus.fwd_d_1 !== 32'h33) begin errors++; $display("FAIL fwd_inflight got %h want 33", bus.fwd_d_1); end
`endif
        tick();
        checks++; if (bus.hz_1 !== 1'b0) begin errors++; $display("FAIL hz_clear got %0b want 0", bus.hz_1); end
`ifdef WB_FWD_EN
        checks++; if (bus.fwd_v_1 !== 1'b0 || bus.fwd_d_1 !== 32'h0) begin
            errors++; $display("FAIL fwd_clear got %0b/%h want 0/0", bus.fwd_v_1, bus.fwd_d_1); end
`endif
        // Two queued loads to r10 behind ALU traffic: youngest data forwards
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd11; bus.alu_data = 32'h77;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd10; bus.mem_data = 32'hA1;
        tick();
        bus.mem_data = 32'hA2;
        tick();
        bus.mem_valid = 1'b0;
        bus.ra_1 = 5'd0; bus.ra_2 = 5'd10;
        #1;
        checks++; if (bus.hz_2 !== 1'b1 || bus.hz_1 !== 1'b0) begin
            errors++; $display("FAIL hz_multi got %0b/%0b want 0/1", bus.hz_1, bus.hz_2); end
`ifdef WB_FWD_EN
        checks++; if (bus.fwd_d_2 !== 32'hA2) begin errors++; $display("FAIL fwd_youngest got %h want a2", bus.fwd_d_2); end
`endif
        idle();
        bus.ra_2 = 5'd0;
        tick(); tick(); tick();
        checks++; if (bus.count !== 3'd0 || bus.werf !== 1'b0) begin
            errors++; $display("FAIL hz_drain got %0d/%0b want 0/0", bus.count, bus.werf); end
    endtask

    task automatic test_reset_mid;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd20; bus.alu_data = 32'h20;
        for (int i = 1; i <= 3; i++) begin
            bus.mem_valid = 1'b1; bus.mem_rd = 5'(i); bus.mem_data = 32'h200 + i;
            tick();
        end
        checks++; if (bus.count !== 3'd3 || bus.werf !== 1'b1) begin
            errors++; $display("FAIL mid_prep got %0d/%0b want 3/1", bus.count, bus.werf); end
        #2;
        rst = 1'b1;
        idle();
        #1;
        checks++; if (bus.werf !== 1'b0 || bus.count !== 3'd0 || bus.mem_ready !== 1'b1) begin
            errors++; $display("FAIL mid_reset got %0b/%0d/%0b want 0/0/1", bus.werf, bus.count, bus.mem_ready); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.werf !== 1'b0 || bus.count !== 3'd0) begin
                errors++; $display("FAIL post_reset_%0d got %0b/%0d want 0/0", i, bus.werf, bus.count); end
        end
    endtask

    initial begin
        test_reset();
        test_alu_single();
        test_fill_drain();
        test_waw_kill();
        test_waw_younger();
        test_zero_rd();
        test_hazard();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
